code_debounce_queue: RTL and testbench
======================================

Name: code_debounce_queue

Overview:
- Sits directly downstream of the 86-input priority encoder; consumes its 7-bit code (1..86 = active input, 127 = none/disabled).
- Debounces the code: a value counts only after it holds for STABLE_CYCLES consecutive clocks.
- Each committed change is time-stamped and queued in a small FIFO; the host drains the FIFO through a valid/ready handshake.

Parameters:
- CODE_W, 7, width of encoder code
- IDLE_CODE, 127, code meaning "no input active"
- STABLE_CYCLES, 4, consecutive identical samples required to commit (legal range 1..255)
- FIFO_DEPTH, 8, event queue entries (power of 2, >=2)
- TS_W, 16, timestamp width
- REPORT_IDLE, 1, 1 = transitions to IDLE_CODE are queued; 0 = they only update cur_code

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- code_in  in  CODE_W  encoder output, sampled every rising edge
- clr  in  1  synchronous flush
- evt_ready  in  1  consumer accepts head event
- ovf_clr  in  1  clears sticky overflow
- evt_valid  out  1  FIFO non-empty
- evt_code  out  CODE_W  head event code
- evt_time  out  TS_W  head event timestamp
- fill  out  $clog2(FIFO_DEPTH)+1  entries held
- cur_code  out  CODE_W  last committed code
- ovf  out  1  sticky: an event was dropped

Behaviour:
- Reset (rst_n low, async):
  - evt_valid=0, fill=0, ovf=0, cur_code=IDLE_CODE.
  - Internal candidate=IDLE_CODE, stable count=0, timestamp=0.
  - evt_code/evt_time read 0.
- Timestamp: free-running TS_W counter, +1 every clock, wraps 2^TS_W-1 -> 0. It is not affected by clr.
- Qualifier FSM, states Q_WAIT and Q_HELD:
  - Q_WAIT: on each edge, if code_in != candidate, set candidate=code_in and cnt=1.
  - Q_WAIT: otherwise cnt+1. When the edge makes cnt==STABLE_CYCLES, commit and go to Q_HELD.
  - Q_HELD: if code_in != candidate, set candidate=code_in, cnt=1, go to Q_WAIT. Otherwise stay; no repeat commits.
  - STABLE_CYCLES=1: every edge whose sample differs from candidate commits immediately.
- Commit:
  - If candidate == cur_code: nothing happens (glitch-and-return is suppressed).
  - Else cur_code is updated on the commit edge.
  - An event {candidate, timestamp value at that edge} is pushed, unless candidate==IDLE_CODE and REPORT_IDLE=0.
- Latency: new code first sampled at edge E1. With an empty FIFO, evt_valid rises after edge E(STABLE_CYCLES), the same edge cur_code updates.
- Codes 0 and 87..126 are treated as ordinary codes; no special handling.
- FIFO:
  - First-word-fall-through; evt_code/evt_time are valid whenever evt_valid=1.
  - Pop occurs on an edge with evt_valid & evt_ready. evt_ready while empty is ignored.
  - Outputs are stable while evt_valid=1 and evt_ready=0.
- Full FIFO:
  - Push while full with no pop in the same edge: the event is dropped, ovf set to 1, cur_code still updates.
  - Push and pop on the same edge while full: both succeed, fill stays FIFO_DEPTH, no overflow.
  - Push and pop on the same edge while fill=1: fill stays 1, the new event becomes head.
- ovf_clr: clears ovf on the next edge. If an overflow occurs on the same edge, set wins.
- clr (synchronous), on the next edge:
  - FIFO emptied, ovf cleared.
  - cur_code and candidate set to IDLE_CODE, cnt=0, FSM to Q_WAIT.
  - Any push or pop on that edge is discarded; clr wins.
- Reset asserted mid-operation: all state returns to reset values immediately; queued events are lost.

Decomposition:
- Package encdeb_pkg:
  - CODE_W and IDLE_CODE constants.
  - Qualifier state enum {Q_WAIT, Q_HELD}.
  - Packed event struct {code, time} used as the FIFO word.
- One sub-module: evt_fifo, a synchronous FWFT FIFO parameterised on width/depth, with a flush input, fill count, and full/empty.
- Qualifier, timestamp and overflow logic live in the top.

Test Plan:
- Reset with code_in=127 held: after rst_n rises and 10 clocks, evt_valid=0, cur_code=127, fill=0.
- code_in 127->5, held, STABLE_CYCLES=4, timestamp 0 at first sample edge E1: after E4, evt_valid=1, evt_code=5, evt_time=3, cur_code=5.
- Glitch: code_in 5->9 for 2 clocks then back to 5: no event queued, cur_code stays 5.
- evt_ready=0, nine distinct stable codes 1..9 committed, FIFO_DEPTH=8: fill=8, ovf=1, cur_code=9.
  - Then draining with evt_ready=1 yields codes 1..8 in order; code 9 is dropped.
- FIFO full with evt_ready=1 and a commit on the same edge: fill stays 8, ovf stays 0, new event is last out.
- clr asserted with fill=3 and a commit on the same edge: next cycle fill=0, evt_valid=0, cur_code=127, ovf=0.
  - Timestamp continues counting without reset.

Source files
------------

// File: rtl/encdeb_pkg.sv
// rtl/encdeb_pkg.sv - shared constants, qualifier states and event word for the code debouncer
package encdeb_pkg;

  localparam int CODE_W = 7;
  localparam logic [CODE_W-1:0] IDLE_CODE = 7'd127;
  localparam int TS_W = 16;

  typedef enum logic {Q_WAIT, Q_HELD} q_state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [TS_W-1:0]   stamp;
  } evt_t;

endpackage

// File: rtl/code_debounce_queue_evt_fifo.sv
// rtl/code_debounce_queue_evt_fifo.sv - first-word-fall-through event FIFO with flush and fill count
module evt_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign w_rd  = rd_en & ~empty;
  assign w_wr  = wr_en & (~full | w_rd);
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !flush) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/code_debounce_queue.sv
// rtl/code_debounce_queue.sv - debounces encoder codes and queues time-stamped changes
module code_debounce_queue
  import encdeb_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter bit REPORT_IDLE   = 1'b1,
  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              clr,
  input  logic              evt_ready,
  input  logic              ovf_clr,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  output logic [TS_W-1:0]   evt_time,
  output logic [FILL_W-1:0] fill,
  output logic [CODE_W-1:0] cur_code,
  output logic              ovf
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  q_state_e          r_state, w_state_nxt;
  logic [CODE_W-1:0] r_cand, w_cand_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [CODE_W-1:0] r_cur;
  logic [TS_W-1:0]   r_ts;
  logic              r_ovf;
  logic              w_commit, w_changed, w_push, w_pop, w_drop;
  logic              w_full, w_empty;
  evt_t              w_head, w_new_evt;

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    if (code_in != r_cand) begin
      w_cand_nxt  = code_in;
      w_cnt_nxt   = 8'd1;
      w_state_nxt = Q_WAIT;
    end else if (r_state == Q_WAIT) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
    // Covers STABLE_CYCLES=1, where a fresh sample commits on the edge it first appears.
    if (w_state_nxt == Q_WAIT && w_cnt_nxt == STABLE_CNT) begin
      w_commit    = 1'b1;
      w_state_nxt = Q_HELD;
    end
  end

  assign w_changed = w_commit && (w_cand_nxt != r_cur);
  assign w_push    = w_changed && (REPORT_IDLE || (w_cand_nxt != IDLE_CODE));
  assign w_pop     = ~w_empty & evt_ready;
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_new_evt = '{code: w_cand_nxt, stamp: r_ts};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= Q_WAIT;
      r_cand  <= IDLE_CODE;
      r_cnt   <= '0;
      r_cur   <= IDLE_CODE;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_state <= Q_WAIT;
      r_cand  <= IDLE_CODE;
      r_cnt   <= '0;
      r_cur   <= IDLE_CODE;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_changed) r_cur <= w_cand_nxt;
      if (w_drop) r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end

  evt_fifo #(
    .WIDTH($bits(evt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clr),
    .wr_en   (w_push),
    .wr_data (w_new_evt),
    .rd_en   (evt_ready),
    .rd_data (w_head),
    .count   (fill),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign evt_valid = ~w_empty;
  assign evt_code  = w_head.code;
  assign evt_time  = w_head.stamp;
  assign cur_code  = r_cur;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_code_debounce_queue.sv
// tb/tb_code_debounce_queue.sv - self-checking bench for code_debounce_queue
module tb_code_debounce_queue;

  localparam int STABLE = 4;
  localparam int DEPTH  = 8;
  localparam int IDLE   = 127;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] code_in = 7'd127;
  logic       clr = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [6:0] evt_code;
  logic [15:0] evt_time;
  logic [3:0] fill;
  logic [6:0] cur_code;
  logic       ovf;

  int total = 0;
  int bad = 0;

  code_debounce_queue #(
    .STABLE_CYCLES(STABLE),
    .FIFO_DEPTH(DEPTH),
    .REPORT_IDLE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .clr(clr),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_time(evt_time), .fill(fill),
    .cur_code(cur_code), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int stamp;
  } mevt_t;

  mevt_t mq[$];
  int    m_cur, m_last, m_run, m_ts;
  bit    m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cur = IDLE; m_last = IDLE; m_run = 0; m_ts = 0; m_ovf = 0;
  endtask

  // Sample history view: a code commits on the edge its run of identical samples reaches STABLE.
  task automatic model_step();
    bit pop, push;
    mevt_t e;
    pop  = (mq.size() > 0) && evt_ready;
    push = 0;
    if (clr) begin
      mq.delete();
      m_cur = IDLE; m_last = IDLE; m_run = 0; m_ovf = 0;
    end else begin
      if (int'(code_in) == m_last && m_run > 0) m_run++;
      else begin
        m_last = int'(code_in);
        m_run = 1;
      end
      if (m_run == STABLE && m_last != m_cur) begin
        m_cur = m_last;
        push = 1;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) begin
          e.code = m_cur;
          e.stamp = m_ts;
          mq.push_back(e);
        end else m_ovf = 1;
      end else if (ovf_clr) m_ovf = 0;
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic check_all();
    chk("evt_valid", int'(evt_valid), (mq.size() > 0) ? 1 : 0);
    chk("fill", int'(fill), mq.size());
    chk("cur_code", int'(cur_code), m_cur);
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("evt_code", int'(evt_code), (mq.size() > 0) ? mq[0].code : 0);
    chk("evt_time", int'(evt_time), (mq.size() > 0) ? mq[0].stamp : 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input int c, input int n);
    code_in = 7'(c);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_cur", int'(cur_code), IDLE);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int first_out, last_out, t0;

  initial begin
    code_in = 7'd127;
    @(negedge clk);
    do_reset();
    hold(IDLE, 10);
    chk("idle_valid", int'(evt_valid), 0);
    chk("idle_cur", int'(cur_code), 127);
    chk("idle_fill", int'(fill), 0);

    do_reset();
    hold(5, 3);
    chk("lat_pre_valid", int'(evt_valid), 0);
    hold(5, 1);
    chk("lat_valid", int'(evt_valid), 1);
    chk("lat_code", int'(evt_code), 5);
    chk("lat_time", int'(evt_time), 3);
    chk("lat_cur", int'(cur_code), 5);

    hold(9, 2);
    hold(5, 6);
    chk("glitch_fill", int'(fill), 1);
    chk("glitch_cur", int'(cur_code), 5);
    evt_ready = 1'b1;
    hold(5, 1);
    evt_ready = 1'b0;
    chk("glitch_drained", int'(fill), 0);

    for (int c = 1; c <= 9; c++) hold(c, 4);
    chk("ovf_fill", int'(fill), 8);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_cur", int'(cur_code), 9);
    evt_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", int'(evt_code), i);
      hold(9, 1);
    end
    evt_ready = 1'b0;
    chk("drain_empty", int'(evt_valid), 0);
    chk("ovf_sticky", int'(ovf), 1);

    ovf_clr = 1'b1;
    hold(9, 1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);
    for (int c = 1; c <= 8; c++) hold(c, 4);
    hold(20, 3);
    evt_ready = 1'b1;
    hold(20, 1);
    evt_ready = 1'b0;
    chk("fullpp_fill", int'(fill), 8);
    chk("fullpp_ovf", int'(ovf), 0);
    evt_ready = 1'b1;
    first_out = int'(evt_code);
    last_out = 0;
    for (int i = 0; i < 8; i++) begin
      last_out = int'(evt_code);
      hold(20, 1);
    end
    evt_ready = 1'b0;
    chk("fullpp_first", first_out, 2);
    chk("fullpp_last", last_out, 20);

    hold(30, 4);
    hold(31, 4);
    hold(32, 4);
    chk("clr_pre_fill", int'(fill), 3);
    hold(33, 3);
    clr = 1'b1;
    hold(33, 1);
    clr = 1'b0;
    chk("clr_fill", int'(fill), 0);
    chk("clr_valid", int'(evt_valid), 0);
    chk("clr_cur", int'(cur_code), 127);
    chk("clr_ovf", int'(ovf), 0);
    t0 = m_ts;
    hold(40, 4);
    chk("clr_ts_continues", int'(evt_time), t0 + 3);
    chk("clr_ts_nonzero", (int'(evt_time) > 100) ? 1 : 0, 1);

    #2;
    do_reset();
    hold(IDLE, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
